// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants, stall-bit indices and payload layout for the inter-stage pipeline registers.
package pipe_stage_reg_pkg;

   localparam logic Stop      = 1'b1;
   localparam logic NoStop    = 1'b0;
   localparam logic RstEnable = 1'b1;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   localparam int STALL_PC  = 0;
   localparam int STALL_ID  = 1;
   localparam int STALL_EX  = 2;
   localparam int STALL_MEM = 3;
   localparam int STALL_WB  = 4;

   // ID/EX payload layout inside the default 160-bit lane word, LSB first.
   localparam int ALUOP_OFF  = 0;
   localparam int ALUSEL_OFF = 8;
   localparam int REG1_OFF   = 11;
   localparam int REG2_OFF   = 43;
   localparam int WD_OFF     = 75;
   localparam int WREG_OFF   = 80;
   localparam int LINK_OFF   = 81;
   localparam int INST_OFF   = 113;
   localparam int EXCEPT_OFF = 145;

   typedef enum logic [2:0] {
      ActReset,
      ActFlush,
      ActBubble,
      ActAdvance,
      ActHold
   } stage_act_e;

   function automatic logic [2:0] countOnes(input logic [3:0] v);
      countOnes = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/pipe_stage_reg_lane_slot.sv
// One issue lane of a pipeline register: valid bit plus payload with bubble/kill/hold control.
module pipe_lane_slot
   import pipe_stage_reg_pkg::*;
#(
   parameter int DATA_W = 160,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  stage_act_e        act_i,
   input  logic              valid_i,
   input  logic              kill_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic              valid_next_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   // A lane that ends up invalid always carries the bubble pattern, never stale data.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      case (act_i)
         ActReset, ActFlush, ActBubble: begin
            valid_d = 1'b0;
            data_d  = BUBBLE_VAL;
         end
         ActAdvance: begin
            valid_d = valid_i & ~kill_i;
            data_d  = valid_d ? data_i : BUBBLE_VAL;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= BUBBLE_VAL;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o      = valid_q;
   assign valid_next_o = valid_d;
   assign data_o       = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised multi-lane pipeline register with sideband and valid-lane count.
// Optional hold/bubble/flush performance counters are enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int LANES   = 1,
   parameter int DATA_W  = 160,
   parameter int SIDE_W  = 1,
   parameter int STALL_W = 5,
   parameter int STAGE   = 1,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter int CNT_W   = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [STALL_W-1:0]          stall,
   input  logic                        flush,
   input  logic [LANES-1:0]            lane_kill_i,
   input  logic [LANES-1:0]            in_valid,
   input  logic [LANES*DATA_W-1:0]     in_data,
   input  logic [SIDE_W-1:0]           in_side,
   output logic [LANES-1:0]            out_valid,
   output logic [LANES*DATA_W-1:0]     out_data,
   output logic [SIDE_W-1:0]           out_side,
   output logic [$clog2(LANES+1)-1:0]  out_cnt
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]            perf_stall_cnt,
   output logic [CNT_W-1:0]            perf_bubble_cnt,
   output logic [CNT_W-1:0]            perf_flush_cnt
`endif
);

   localparam int CW = $clog2(LANES+1);

   if (STAGE + 1 >= STALL_W || LANES < 1 || LANES > 4 || CNT_W < 1) begin : gBadParams
      $error("pipe_stage_reg: illegal STAGE/STALL_W/LANES/CNT_W combination");
   end

   stage_act_e        act;
   logic [LANES-1:0]  validNext;
   logic [SIDE_W-1:0] side_q, side_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   // Strict priority: reset, flush, advance (overrides downstream stall), bubble, hold.
   always_comb begin
      act = ActHold;
      if (rst == RstEnable)
         act = ActReset;
      else if (flush)
         act = ActFlush;
      else if (stall[STAGE] == NoStop)
         act = ActAdvance;
      else if (stall[STAGE+1] == NoStop)
         act = ActBubble;
   end

   for (genvar l = 0; l < LANES; l++) begin : gLane
      pipe_lane_slot #(
         .DATA_W     (DATA_W),
         .BUBBLE_VAL (BUBBLE_VAL)
      ) uSlot (
         .clk          (clk),
         .rst          (rst),
         .act_i        (act),
         .valid_i      (in_valid[l]),
         .kill_i       (lane_kill_i[l]),
         .data_i       (in_data[l*DATA_W +: DATA_W]),
         .valid_o      (out_valid[l]),
         .valid_next_o (validNext[l]),
         .data_o       (out_data[l*DATA_W +: DATA_W])
      );
   end

   // The sideband survives a bubble so a delay-slot flag is not lost.
   always_comb begin
      side_d = side_q;
      cnt_d  = CW'(countOnes(4'(validNext)));
      case (act)
         ActReset, ActFlush: side_d = '0;
         ActAdvance:         side_d = in_side;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         side_q <= '0;
         cnt_q  <= '0;
      end else begin
         side_q <= side_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_side = side_q;
   assign out_cnt  = cnt_q;

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
   logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
   logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      satInc = (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Counters saturate and are only cleared by reset, never by flush.
   always_comb begin
      stallCnt_d  = stallCnt_q;
      bubbleCnt_d = bubbleCnt_q;
      flushCnt_d  = flushCnt_q;
      case (act)
         ActHold:   stallCnt_d  = satInc(stallCnt_q);
         ActBubble: bubbleCnt_d = satInc(bubbleCnt_q);
         ActFlush:  flushCnt_d  = satInc(flushCnt_q);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stallCnt_q  <= '0;
         bubbleCnt_q <= '0;
         flushCnt_q  <= '0;
      end else begin
         stallCnt_q  <= stallCnt_d;
         bubbleCnt_q <= bubbleCnt_d;
         flushCnt_q  <= flushCnt_d;
      end
   end

   assign perf_stall_cnt  = stallCnt_q;
   assign perf_bubble_cnt = bubbleCnt_q;
   assign perf_flush_cnt  = flushCnt_q;
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && stall[STAGE] == NoStop && stall[STAGE+1] == Stop)
         $warning("pipe_stage_reg: advance while downstream stage is stalled");
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (LANES=2, STAGE=1, CNT_W=4).
module tb_pipe_stage_reg;

   localparam int LANES  = 2;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;
   localparam logic [DATA_W-1:0] BUB = 32'hDEAD_BEEF;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [4:0]              stall;
   logic                    flush;
   logic [LANES-1:0]        lane_kill_i;
   logic [LANES-1:0]        in_valid;
   logic [LANES*DATA_W-1:0] in_data;
   logic [0:0]              in_side;
   logic [LANES-1:0]        out_valid;
   logic [LANES*DATA_W-1:0] out_data;
   logic [0:0]              out_side;
   logic [1:0]              out_cnt;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0]        perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt;
`endif

   int  checksTotal  = 0;
   int  checksPassed = 0;
   bit  invariantOn  = 1'b0;

   pipe_stage_reg #(
      .LANES      (LANES),
      .DATA_W     (DATA_W),
      .SIDE_W     (1),
      .STALL_W    (5),
      .STAGE      (1),
      .BUBBLE_VAL (BUB),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush),
      .lane_kill_i (lane_kill_i),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_side     (in_side),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_side    (out_side),
      .out_cnt     (out_cnt)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_bubble_cnt (perf_bubble_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // out_cnt must track the popcount of out_valid on every cycle after reset.
   always @(negedge clk) begin
      if (invariantOn) begin
         checksTotal++;
         if (out_cnt !== 2'(out_valid[0]) + 2'(out_valid[1]))
            $display("[TB] FAIL cnt_invariant: out_cnt=%0d out_valid=%b", out_cnt, out_valid);
         else
            checksPassed++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 5'b00000; flush = 1'b0; lane_kill_i = 2'b00;
      in_valid = 2'b11; in_data = {32'h0000_00AA, 32'h0000_00BB}; in_side = 1'b1;
      tick();
      checksTotal++;
      if ({out_valid, out_data, out_side, out_cnt} !== {2'b00, BUB, BUB, 1'b0, 2'd0})
         $display("[TB] FAIL reset_state: got v=%b d=%h s=%b c=%0d", out_valid, out_data, out_side, out_cnt);
      else checksPassed++;
`ifdef PIPE_STAGE_PERF_EN
      checksTotal++;
      if ({perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt} !== 12'h000)
         $display("[TB] FAIL reset_perf: got %h %h %h expected 0", perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt);
      else checksPassed++;
`endif
      invariantOn = 1'b1;
   endtask

   task automatic test_advance();
      rst = 1'b0; in_valid = 2'b11; in_data = {32'h22, 32'h11}; in_side = 1'b1;
      tick();
      checksTotal++;
      if ({out_valid, out_data, out_side, out_cnt} !== {2'b11, 32'h22, 32'h11, 1'b1, 2'd2})
         $display("[TB] FAIL advance_both: got v=%b d=%h s=%b c=%0d expected v=11 d=22/11 s=1 c=2", out_valid, out_data, out_side, out_cnt);
      else checksPassed++;
      in_valid = 2'b10; in_data = {32'h55, 32'h66};
      tick();
      checksTotal++;
      if ({out_valid, out_data, out_side, out_cnt} !== {2'b10, 32'h55, BUB, 1'b1, 2'd1})
         $display("[TB] FAIL advance_lane1: got v=%b d=%h s=%b c=%0d expected v=10 d=55/bubble c=1", out_valid, out_data, out_side, out_cnt);
      else checksPassed++;
   endtask

   task automatic test_bubble();
      stall = 5'b00010; in_valid = 2'b11; in_side = 1'b0; lane_kill_i = 2'b11;
      tick();
      checksTotal++;
      if ({out_valid, out_data, out_cnt} !== {2'b00, BUB, BUB, 2'd0})
         $display("[TB] FAIL bubble_lanes: got v=%b d=%h c=%0d expected bubble", out_valid, out_data, out_cnt);
      else checksPassed++;
      checksTotal++;
      if (out_side !== 1'b1)
         $display("[TB] FAIL bubble_side_hold: got %b expected 1", out_side);
      else checksPassed++;
`ifdef PIPE_STAGE_PERF_EN
      checksTotal++;
      if (perf_bubble_cnt !== 4'd1)
         $display("[TB] FAIL bubble_perf: got %0d expected 1", perf_bubble_cnt);
      else checksPassed++;
`endif
   endtask

   task automatic test_hold();
      stall = 5'b00000; lane_kill_i = 2'b00; in_valid = 2'b11; in_data = {32'h88, 32'h77}; in_side = 1'b0;
      tick();
      stall = 5'b00110; in_valid = 2'b00; in_data = {32'hFF, 32'hEE}; in_side = 1'b1; lane_kill_i = 2'b11;
      for (int i = 0; i < 3; i++) begin
         tick();
         checksTotal++;
         if ({out_valid, out_data, out_side, out_cnt} !== {2'b11, 32'h88, 32'h77, 1'b0, 2'd2})
            $display("[TB] FAIL hold_cycle%0d: got v=%b d=%h s=%b c=%0d expected v=11 d=88/77 s=0 c=2", i, out_valid, out_data, out_side, out_cnt);
         else checksPassed++;
      end
`ifdef PIPE_STAGE_PERF_EN
      checksTotal++;
      if (perf_stall_cnt !== 4'd3)
         $display("[TB] FAIL hold_perf: got %0d expected 3", perf_stall_cnt);
      else checksPassed++;
`endif
   endtask

   task automatic test_flush();
      stall = 5'b00000; lane_kill_i = 2'b00; in_valid = 2'b11; in_data = {32'h99, 32'h98}; in_side = 1'b1;
      tick();
      flush = 1'b1; stall = 5'b00010;
      tick();
      flush = 1'b0;
      checksTotal++;
      if ({out_valid, out_data, out_side, out_cnt} !== {2'b00, BUB, BUB, 1'b0, 2'd0})
         $display("[TB] FAIL flush_over_stall: got v=%b d=%h s=%b c=%0d expected cleared", out_valid, out_data, out_side, out_cnt);
      else checksPassed++;
`ifdef PIPE_STAGE_PERF_EN
      checksTotal++;
      if ({perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt} !== {4'd3, 4'd1, 4'd1})
         $display("[TB] FAIL flush_perf: got %0d/%0d/%0d expected 3/1/1", perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt);
      else checksPassed++;
`endif
   endtask

   task automatic test_kill();
      stall = 5'b00000; in_valid = 2'b11; lane_kill_i = 2'b10; in_data = {32'hB2, 32'hA1};
      tick();
      checksTotal++;
      if ({out_valid, out_data, out_cnt} !== {2'b01, BUB, 32'hA1, 2'd1})
         $display("[TB] FAIL kill_advance: got v=%b d=%h c=%0d expected v=01 d=bubble/A1 c=1", out_valid, out_data, out_cnt);
      else checksPassed++;
      stall = 5'b00110; lane_kill_i = 2'b01; in_data = {32'hC2, 32'hC1};
      tick();
      checksTotal++;
      if ({out_valid, out_data, out_cnt} !== {2'b01, BUB, 32'hA1, 2'd1})
         $display("[TB] FAIL kill_ignored_hold: got v=%b d=%h c=%0d expected held", out_valid, out_data, out_cnt);
      else checksPassed++;
   endtask

   task automatic test_saturation();
`ifdef PIPE_STAGE_PERF_EN
      stall = 5'b00110;
      for (int i = 0; i < 20; i++) tick();
      checksTotal++;
      if (perf_stall_cnt !== 4'hF)
         $display("[TB] FAIL perf_saturate: got %h expected F", perf_stall_cnt);
      else checksPassed++;
`endif
   endtask

   task automatic test_reset_during_hold();
      stall = 5'b00110; rst = 1'b1;
      tick();
      rst = 1'b0;
      checksTotal++;
      if ({out_valid, out_data, out_side, out_cnt} !== {2'b00, BUB, BUB, 1'b0, 2'd0})
         $display("[TB] FAIL reset_in_hold: got v=%b d=%h s=%b c=%0d expected cleared", out_valid, out_data, out_side, out_cnt);
      else checksPassed++;
`ifdef PIPE_STAGE_PERF_EN
      checksTotal++;
      if ({perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt} !== 12'h000)
         $display("[TB] FAIL reset_in_hold_perf: got %h %h %h expected 0", perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt);
      else checksPassed++;
`endif
      stall = 5'b00000; lane_kill_i = 2'b00; in_valid = 2'b01; in_data = {32'hD2, 32'hC3}; in_side = 1'b1;
      tick();
      checksTotal++;
      if ({out_valid, out_data, out_side, out_cnt} !== {2'b01, BUB, 32'hC3, 1'b1, 2'd1})
         $display("[TB] FAIL post_reset_advance: got v=%b d=%h s=%b c=%0d expected v=01 d=bubble/C3 s=1 c=1", out_valid, out_data, out_side, out_cnt);
      else checksPassed++;
   endtask

   initial begin
      test_reset();
      test_advance();
      test_bubble();
      test_hold();
      test_flush();
      test_kill();
      test_saturation();
      test_reset_during_hold();
      @(negedge clk);
      invariantOn = 1'b0;
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
